// File: rtl/mod_addsub_seq.sv
// mod_addsub_seq: digit-serial modular adder/subtractor, (a op b) mod m.
//
// The operation runs in two carry-chained passes of W bits per cycle over an
// internal width of DIGITS*W bits. DIGITS*W is at least N+1, which leaves one
// guard bit above N so that a+b never overflows.
//   Pass 1 forms the raw result r = a + b, or a + ~b + 1 for subtraction.
//   Pass 2 forms the corrected value t = r - m for add/double, or r + m for
//   sub/negate.
// One extra cycle then picks r or t, registers the result and pulses done.
//
// Ports:
//   clk     in   rising-edge clock
//   resetn  in   asynchronous, active-low reset
//   start   in   request, sampled only while idle
//   op      in   00 add, 01 sub, 10 double (a+a), 11 negate (0-a)
//   in_a    in   operand a (a < m)
//   in_b    in   operand b (b < m); ignored for double/negate
//   in_m    in   modulus (0 < m < 2^N)
//   busy    out  high from the accepted start until the done cycle
//   done    out  one-cycle pulse; result is valid in that cycle
//   result  out  registered result, held until the next done
module mod_addsub_seq #(
  parameter int N = 381,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  // DIGITS = ceil((N+1)/W)
  localparam int DIGITS = (N + W) / W;
  localparam int DW     = DIGITS * W;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_FINAL = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          c1_q, c1_d;
  logic          c2_q, c2_d;
  logic          sub_q, sub_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] m_q, m_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] t_q, t_d;
  logic [N-1:0]  result_q, result_d;
  logic          done_q, done_d;

  logic [W-1:0]  a_dig, b_dig, m_dig, r_dig;
  logic [W-1:0]  x_dig, y_dig;
  logic [W:0]    sum;
  logic          use_t;

  // A single W-bit adder serves both passes; the operands are steered by state.
  always_comb begin
    a_dig = a_q[cnt_q*W +: W];
    b_dig = b_q[cnt_q*W +: W];
    m_dig = m_q[cnt_q*W +: W];
    r_dig = r_q[cnt_q*W +: W];
    if (state_q == S_PASS2) begin
      x_dig = r_dig;
      y_dig = sub_q ? m_dig : ~m_dig;
    end else begin
      x_dig = a_dig;
      y_dig = sub_q ? ~b_dig : b_dig;
    end
    sum = {1'b0, x_dig} + {1'b0, y_dig} + {{W{1'b0}}, carry_q};
  end

  // For add/double, t = r - m is taken when it did not borrow (r >= m).
  // For sub/negate, r is kept when a - b did not borrow, otherwise t = r + m.
  assign use_t = sub_q ? ~c1_q : c2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    r_d      = r_q;
    t_d      = t_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Double reuses a as b; negate is computed as 0 - a.
          a_d     = (op == 2'b11) ? '0 : DW'(in_a);
          b_d     = op[1] ? DW'(in_a) : DW'(in_b);
          m_d     = DW'(in_m);
          sub_d   = op[0];
          cnt_d   = '0;
          carry_d = op[0];
          state_d = S_PASS1;
        end
      end

      S_PASS1: begin
        r_d[cnt_q*W +: W] = sum[W-1:0];
        if (cnt_q == LAST) begin
          c1_d    = sum[W];
          cnt_d   = '0;
          // Pass 2 subtracts m for add/double, so it needs the +1 carry-in.
          carry_d = ~sub_q;
          state_d = S_PASS2;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          carry_d = sum[W];
        end
      end

      S_PASS2: begin
        t_d[cnt_q*W +: W] = sum[W-1:0];
        if (cnt_q == LAST) begin
          c2_d    = sum[W];
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = S_FINAL;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          carry_d = sum[W];
        end
      end

      S_FINAL: begin
        result_d = use_t ? t_q[N-1:0] : r_q[N-1:0];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      r_q      <= r_d;
      t_q      <= t_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // busy drops in the done cycle, so a start in that cycle is accepted.
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/mod_addsub_seq.md
Name: mod_addsub_seq

Overview:
- Parametrised, digit-serial modular adder/subtractor for the ECDSA field/scalar datapath.
- Computes (a op b) mod m over an N-bit modulus in two carry-chained passes of W bits per cycle. Pass 1 computes the raw result; pass 2 applies the modulus correction.
- Adds four operation modes (add, sub, double, negate), a busy flag, back-to-back start acceptance and a registered, held result.

Parameters:
- N, 381, operand/modulus width in bits.
- W, 128, digit width processed per cycle; legal range 1..N+1.
- DIGITS = ceil((N+1)/W) is derived (localparam). Internal datapath is DIGITS*W bits: operands zero-extended, one guard bit above N.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 add, 01 sub, 10 double (a+a), 11 negate (0-a); captured at start.
- in_a  input  N  operand a; requires a < m.
- in_b  input  N  operand b; requires b < m; ignored for op 10/11.
- in_m  input  N  modulus; requires 0 < m < 2^N.
- busy  output  1  high from the accepted start until the cycle done is asserted.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  N  registered; held until the next done.

Behaviour:
- Reset (asynchronous): state IDLE; busy=0, done=0, result=0; digit counter, carry, and operand/temp registers all cleared.
- FSM states: IDLE, PASS1, PASS2, FINAL.
- IDLE: if start=1, capture a, b (b:=a for double; a:=0, b:=a for negate), m and op. Go to PASS1 with counter=0 and carry-in = 1 for sub/negate, 0 for add/double. Set busy=1.
- PASS1: each cycle processes digit[counter] of r = a + b, or a + ~b + 1 for sub/negate. The carry is registered between digits. After digit DIGITS-1: latch c1 (final carry/no-borrow flag), load counter=0, go to PASS2.
- PASS2: each cycle processes digit[counter] of t. For add/double, t = r + ~m + 1; for sub/negate, t = r + m. Latch c2 after the last digit, then go to FINAL.
- FINAL (one cycle) selects the result:
  - add/double: result = t if c2=1 (r >= m), else r.
  - sub/negate: result = r if c1=1 (no borrow), else t.
  - Register result[N-1:0], pulse done=1, clear busy, go to IDLE.
- Latency: start sampled at edge k → done=1 in the cycle following edge k+2*DIGITS+1. Defaults (DIGITS=3): 7 edges.
- Back-to-back: start may be high in the same cycle done=1; that start is accepted and busy rises on the next edge. Throughput is one op per 2*DIGITS+2 cycles.
- start while busy=1: ignored; no recapture and no latency change.
- Operand ports may change freely after the capture edge.
- Reset asserted mid-operation: aborts immediately with all outputs at reset values. No done is issued for the aborted op.
- Precondition violated (a >= m, b >= m, or m = 0): result is unspecified, but done still fires at nominal latency and the FSM does not hang.
- The guard bit ensures that a+b ≤ 2m-2 never overflows the internal width.

Test Plan:
- Add and subtract with N=381, W=128, m=23. Sequence: add a=20, b=5 → 2; add a=10, b=13 (a+b=m) → 0; sub a=5, b=20 → 8; sub a=9, b=9 → 0. done must arrive exactly 7 edges after each start.
- Double and negate, m=23: double a=12 → 1; negate a=7 → 16; negate a=0 → 0; double a=22 → 21.
- Wide values, m = 2^381 - 19, a = m-1, b = m-1:
  - add → m-2.
  - sub a=0, b=1 → m-1.
  - These must be checked against a reference model over 10k random vectors with a, b < m, all op values.
- Handshake:
  - start held high continuously for 3 ops → done pulses every 8 cycles and busy never drops mid-op.
  - Extra start pulses while busy=1 → no additional done pulses.
  - Changing in_a after capture does not affect result.
- Reset during PASS2 of an add → busy=0, done=0, result=0 immediately. A fresh add a=1, b=2, m=23 afterwards → 3 at nominal latency.
- Parameter sweep with W=382 (DIGITS=1, latency 3 edges) and W=1 (DIGITS=382, latency 765 edges) → results identical to the default configuration for the m=23 vectors.
